// File: rtl/rng_fill.sv
// rtl/rng_fill.sv - fills RAM words 0..end_addr with entropy words over a pipelined bus port
// Optional feature: define RNG_FILL_HEALTH_EN to discard repeated entropy words and flag health_fail.
module rng_fill (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_rng,
    input  logic [8:0]  addr_rng,
    output logic        ack_rng,
    output logic        busy,
    input  logic        rnd_vld,
    input  logic [31:0] rnd_data,
    output logic        rnd_rdy,
    output logic        ram_cyc_a,
    output logic        ram_stb_a,
    output logic [3:0]  ram_we_a,
    output logic [8:0]  ram_addr_a,
    output logic [31:0] ram_data_in_a,
    input  logic        ram_ack_a,
    input  logic        ram_stall_a,
    output logic        health_fail
);
    typedef enum logic [2:0] {IDLE, GET_RND, WRITE, WAIT_ACK, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  end_addr_q, end_addr_d;
    logic [8:0]  cur_addr_q, cur_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        take_word;

`ifdef RNG_FILL_HEALTH_EN
    logic [31:0] prev_q, prev_d;
    logic        prev_vld_q, prev_vld_d;
    logic        health_q, health_d;

    // A word repeating the previously consumed one is consumed but never written.
    assign take_word   = !(prev_vld_q && (rnd_data == prev_q));
    assign health_fail = health_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            health_q   <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            health_q   <= health_d;
        end
    end

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        health_d   = health_q;
        if (state_q == IDLE && we_rng) begin
            prev_vld_d = 1'b0;
        end else if (state_q == GET_RND && rnd_vld) begin
            prev_d     = rnd_data;
            prev_vld_d = 1'b1;
            if (!take_word) health_d = 1'b1;
        end
    end
`else
    assign take_word   = 1'b1;
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            end_addr_q <= '0;
            cur_addr_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            end_addr_q <= end_addr_d;
            cur_addr_q <= cur_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        end_addr_d = end_addr_q;
        cur_addr_d = cur_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: begin
                if (we_rng) begin
                    end_addr_d = addr_rng;
                    cur_addr_d = '0;
                    state_d    = GET_RND;
                end
            end
            GET_RND: begin
                if (rnd_vld && take_word) begin
                    wr_data_d = rnd_data;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (!ram_stall_a) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ram_ack_a) begin
                    if (cur_addr_q == end_addr_q) begin
                        state_d = DONE;
                    end else begin
                        cur_addr_d = cur_addr_q + 9'd1;
                        state_d    = GET_RND;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are decoded from the state alone, so none depend on same-cycle inputs.
    always_comb begin
        ack_rng       = 1'b0;
        busy          = (state_q != IDLE);
        rnd_rdy       = 1'b0;
        ram_cyc_a     = 1'b0;
        ram_stb_a     = 1'b0;
        ram_we_a      = 4'h0;
        ram_addr_a    = '0;
        ram_data_in_a = '0;
        case (state_q)
            GET_RND: rnd_rdy = 1'b1;
            WRITE: begin
                ram_cyc_a     = 1'b1;
                ram_stb_a     = 1'b1;
                ram_we_a      = 4'hF;
                ram_addr_a    = cur_addr_q;
                ram_data_in_a = wr_data_q;
            end
            WAIT_ACK: ram_cyc_a = 1'b1;
            DONE:     ack_rng   = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rng_fill.sv
// tb/tb_rng_fill.sv - randomized self-checking bench for rng_fill
// Expected writes come from the source word stream; expected latency from the per-word cycle rule.
module tb_rng_fill;
    logic        clk_i = 1'b0, rst_i = 1'b1, we_rng = 1'b0, rnd_vld = 1'b0;
    logic        ram_ack_a = 1'b0, ram_stall_a = 1'b0;
    logic [8:0]  addr_rng = '0;
    logic [31:0] rnd_data = '0;
    logic        ack_rng, busy, rnd_rdy, ram_cyc_a, ram_stb_a, health_fail;
    logic [3:0]  ram_we_a;
    logic [8:0]  ram_addr_a;
    logic [31:0] ram_data_in_a;

    always #5 clk_i = ~clk_i;

    rng_fill dut (
        .clk_i(clk_i), .rst_i(rst_i), .we_rng(we_rng), .addr_rng(addr_rng),
        .ack_rng(ack_rng), .busy(busy), .rnd_vld(rnd_vld), .rnd_data(rnd_data),
        .rnd_rdy(rnd_rdy), .ram_cyc_a(ram_cyc_a), .ram_stb_a(ram_stb_a),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_in_a(ram_data_in_a),
        .ram_ack_a(ram_ack_a), .ram_stall_a(ram_stall_a), .health_fail(health_fail)
    );

    int n_cmp = 0, n_fail = 0;
    int p_vld_low, p_stall, ack_max, gap_start, gap_len, stall_word, stall_len, extra_req_cyc;
    bit noise_en;
    int ack_cyc, ack_cnt, wr_cnt, proto_err;
    logic busy_after, timeout;
    logic [5:0] abort_outs;
    logic [8:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$], src_q[$], exp_q[$];

    task automatic clean_knobs();
        p_vld_low = 0; p_stall = 0; ack_max = 1; gap_start = -1; gap_len = 0;
        stall_word = -1; stall_len = 0; extra_req_cyc = -1; noise_en = 0;
    endtask

    task automatic load_src(input int n, input bit counter);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(counter ? 32'(i + 1) : $urandom);
    endtask

    // Reference: the n words a request should write, taken in order from the source stream.
    task automatic make_expect(input int n);
        logic [31:0] last;
        bit have;
        exp_q.delete(); have = 0; last = '0;
        foreach (src_q[i]) begin
            if (exp_q.size() < n) begin
`ifdef RNG_FILL_HEALTH_EN
                if (!(have && src_q[i] == last)) exp_q.push_back(src_q[i]);
                last = src_q[i]; have = 1;
`else
                exp_q.push_back(src_q[i]);
`endif
            end
        end
    endtask

    // Runs one request cycle by cycle: plays entropy source and RAM slave, records what it sees.
    task automatic do_fill(input logic [8:0] ea, input int abort_after);
        int c, ack_due, stall_left, budget;
        bit stall_done, prev_ss;
        logic [8:0] pa;
        logic [31:0] pd;
        c = 0; ack_due = -1; stall_left = 0; stall_done = 0; prev_ss = 0; pa = '0; pd = '0;
        budget = 20 * (int'(ea) + 1) + 200;
        ack_cyc = -1; ack_cnt = 0; wr_cnt = 0; proto_err = 0; busy_after = 1'bx;
        timeout = 0; abort_outs = '1;
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk_i);
        forever begin
            if (c >= 1 && ack_cyc < 0 && busy !== 1'b1) proto_err++;
            if (ram_we_a !== (ram_stb_a ? 4'hF : 4'h0)) proto_err++;
            if (rnd_rdy && ram_cyc_a) proto_err++;
            if (prev_ss && (ram_stb_a !== 1'b1 || ram_addr_a !== pa || ram_data_in_a !== pd)) proto_err++;
            if (ack_rng === 1'b1) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = c;
            end
            if (ack_cyc >= 0 && c == ack_cyc + 1) begin
                busy_after = busy;
                break;
            end
            we_rng   = (c == 0) || (c == extra_req_cyc);
            addr_rng = (c == 0) ? ea : ~ea;
            rnd_vld  = (src_q.size() > 0) && !(c >= gap_start && c < gap_start + gap_len)
                       && (int'($urandom_range(99)) >= p_vld_low);
            rnd_data = (src_q.size() > 0) ? src_q[0] : $urandom;
            if (ram_stb_a === 1'b1) begin
                if (!stall_done && wr_cnt == stall_word) begin
                    stall_left = stall_len; stall_done = 1;
                end
                ram_stall_a = (stall_left > 0) || (int'($urandom_range(99)) < p_stall);
                if (stall_left > 0) stall_left--;
            end else begin
                ram_stall_a = noise_en && ($urandom_range(1) == 1);
            end
            ram_ack_a = (c == ack_due) || (noise_en && rnd_rdy && $urandom_range(3) == 0);
            if (rnd_rdy && rnd_vld) void'(src_q.pop_front());
            if (ram_stb_a && !ram_stall_a) begin
                wr_addr_q.push_back(ram_addr_a);
                wr_data_q.push_back(ram_data_in_a);
                wr_cnt++;
                ack_due = c + int'($urandom_range(ack_max, 1));
            end
            prev_ss = ram_stb_a && ram_stall_a; pa = ram_addr_a; pd = ram_data_in_a;
            if (abort_after >= 0 && ram_cyc_a && !ram_stb_a && wr_cnt == abort_after + 1) begin
                #2 rst_i = 1'b1;
                #1 abort_outs = {ram_cyc_a, ram_stb_a, busy, ack_rng, rnd_rdy, |ram_we_a};
                break;
            end
            c++;
            if (c > budget) begin
                timeout = 1;
                break;
            end
            @(negedge clk_i);
        end
        we_rng = 0; rnd_vld = 0; ram_ack_a = 0; ram_stall_a = 0; src_q.delete();
        if (rst_i) begin
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        we_rng = 1; rnd_vld = 1; addr_rng = 9'h1FF; ram_ack_a = 1;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({ack_rng, busy, rnd_rdy, ram_cyc_a, ram_stb_a, health_fail, ram_we_a} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {ack_rng, busy, rnd_rdy, ram_cyc_a, ram_stb_a, health_fail, ram_we_a});
        end
        n_cmp++;
        if ({ram_addr_a, ram_data_in_a} !== 41'd0) begin
            n_fail++; $display("FAIL reset_bus: got %h want 0", {ram_addr_a, ram_data_in_a});
        end
        we_rng = 0; rnd_vld = 0; ram_ack_a = 0; rst_i = 0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_counter();
        clean_knobs(); load_src(40, 1); make_expect(32);
        do_fill(9'h01F, -1);
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL counter_timeout: got %b want 0", timeout); end
        n_cmp++; if (ack_cyc != 97) begin n_fail++; $display("FAIL counter_ack_cycle: got %0d want 97", ack_cyc); end
        n_cmp++; if (ack_cnt != 1) begin n_fail++; $display("FAIL counter_ack_pulses: got %0d want 1", ack_cnt); end
        n_cmp++; if (wr_cnt != 32) begin n_fail++; $display("FAIL counter_writes: got %0d want 32", wr_cnt); end
        for (int i = 0; i < 32 && i < wr_cnt; i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== 9'(i) || wr_data_q[i] !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL counter_word %0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 9'(i), 32'(i + 1));
            end
        end
        n_cmp++; if (proto_err != 0) begin n_fail++; $display("FAIL counter_protocol: got %0d errors want 0", proto_err); end
    endtask

    task automatic test_single();
        clean_knobs(); extra_req_cyc = 4; load_src(4, 0); make_expect(1);
        do_fill(9'h000, -1);
        n_cmp++; if (ack_cyc != 4) begin n_fail++; $display("FAIL single_ack_cycle: got %0d want 4", ack_cyc); end
        n_cmp++; if (wr_cnt != 1) begin n_fail++; $display("FAIL single_writes: got %0d want 1", wr_cnt); end
        n_cmp++;
        if (wr_cnt < 1 || wr_addr_q[0] !== 9'h000 || wr_data_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL single_word: got %h/%h want 000/%h", wr_addr_q[0], wr_data_q[0], exp_q[0]);
        end
        n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_stall();
        clean_knobs(); stall_word = 3; stall_len = 5; load_src(12, 0); make_expect(8);
        do_fill(9'h007, -1);
        n_cmp++; if (ack_cyc != 30) begin n_fail++; $display("FAIL stall_ack_cycle: got %0d want 30", ack_cyc); end
        n_cmp++; if (wr_cnt != 8) begin n_fail++; $display("FAIL stall_writes: got %0d want 8", wr_cnt); end
        for (int i = 0; i < 8 && i < wr_cnt; i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== 9'(i) || wr_data_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stall_word %0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 9'(i), exp_q[i]);
            end
        end
        n_cmp++; if (proto_err != 0) begin n_fail++; $display("FAIL stall_stability: got %0d errors want 0", proto_err); end
    endtask

    task automatic test_gap_rereq();
        clean_knobs(); gap_start = 7; gap_len = 10; extra_req_cyc = 20; load_src(20, 0); make_expect(16);
        do_fill(9'h00F, -1);
        n_cmp++; if (ack_cyc != 59) begin n_fail++; $display("FAIL gap_ack_cycle: got %0d want 59", ack_cyc); end
        n_cmp++; if (ack_cnt != 1) begin n_fail++; $display("FAIL gap_ack_pulses: got %0d want 1", ack_cnt); end
        n_cmp++; if (wr_cnt != 16) begin n_fail++; $display("FAIL gap_writes: got %0d want 16", wr_cnt); end
        n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL gap_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_reset_mid();
        clean_knobs(); load_src(40, 0);
        do_fill(9'h01F, 7);
        n_cmp++; if (abort_outs !== 6'd0) begin n_fail++; $display("FAIL abort_outputs: got %b want 000000", abort_outs); end
        n_cmp++; if (wr_cnt != 8 || ack_cnt != 0) begin n_fail++; $display("FAIL abort_progress: got writes %0d acks %0d want 8/0", wr_cnt, ack_cnt); end
        load_src(6, 0); make_expect(3);
        do_fill(9'h002, -1);
        n_cmp++;
        if (wr_cnt != 3 || wr_addr_q[0] !== 9'h000 || wr_data_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL restart_first: got n=%0d %h/%h want 3 000/%h", wr_cnt, wr_addr_q[0], wr_data_q[0], exp_q[0]);
        end
        n_cmp++; if (ack_cyc != 10) begin n_fail++; $display("FAIL restart_ack_cycle: got %0d want 10", ack_cyc); end
    endtask

    task automatic test_boundary_max();
        int bad;
        clean_knobs(); load_src(520, 0); make_expect(512);
        do_fill(9'h1FF, -1);
        n_cmp++; if (ack_cyc != 1537) begin n_fail++; $display("FAIL max_ack_cycle: got %0d want 1537", ack_cyc); end
        n_cmp++; if (wr_cnt != 512) begin n_fail++; $display("FAIL max_writes: got %0d want 512", wr_cnt); end
        bad = 0;
        for (int i = 0; i < 512 && i < wr_cnt; i++)
            if (wr_addr_q[i] !== 9'(i) || wr_data_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL max_contents: got %0d bad words want 0", bad); end
    endtask

    task automatic test_random();
        int ea, bad;
        for (int it = 0; it < 6; it++) begin
            clean_knobs(); p_vld_low = 30; p_stall = 30; ack_max = 3; noise_en = 1;
            ea = int'($urandom_range(40));
            load_src(ea + 8, 0); make_expect(ea + 1);
            do_fill(9'(ea), -1);
            n_cmp++;
            if (timeout !== 1'b0 || ack_cnt != 1 || wr_cnt != ea + 1) begin
                n_fail++; $display("FAIL rand%0d_counts: got to=%b acks=%0d writes=%0d want 0/1/%0d", it, timeout, ack_cnt, wr_cnt, ea + 1);
            end
            bad = 0;
            for (int i = 0; i <= ea && i < wr_cnt; i++)
                if (wr_addr_q[i] !== 9'(i) || wr_data_q[i] !== exp_q[i]) bad++;
            n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_contents: got %0d bad words want 0", it, bad); end
            n_cmp++;
            if (proto_err != 0 || busy_after !== 1'b0 || ack_cyc < 3 * (ea + 1) + 1) begin
                n_fail++; $display("FAIL rand%0d_protocol: got err=%0d busy_after=%b ack=%0d want 0/0/>=%0d", it, proto_err, busy_after, ack_cyc, 3 * (ea + 1) + 1);
            end
        end
    endtask

    task automatic test_repeat();
        logic [31:0] a, last;
        logic exp_hf;
        int bad;
`ifdef RNG_FILL_HEALTH_EN
        exp_hf = 1'b1;
`else
        exp_hf = 1'b0;
`endif
        clean_knobs();
        a = $urandom;
        src_q.delete();
        src_q.push_back(a); src_q.push_back(a); src_q.push_back(a ^ 32'h1);
        src_q.push_back(a ^ 32'h3); src_q.push_back(a ^ 32'h7);
        make_expect(3);
        do_fill(9'h002, -1);
        bad = 0;
        for (int i = 0; i < 3 && i < wr_cnt; i++)
            if (wr_addr_q[i] !== 9'(i) || wr_data_q[i] !== exp_q[i]) bad++;
        n_cmp++;
        if (bad != 0 || wr_cnt != 3) begin n_fail++; $display("FAIL repeat_contents: got %0d bad, %0d writes want 0/3", bad, wr_cnt); end
        n_cmp++; if (health_fail !== exp_hf) begin n_fail++; $display("FAIL repeat_health: got %b want %b", health_fail, exp_hf); end
        last = exp_q[2];
        src_q.delete();
        src_q.push_back(last); src_q.push_back(last ^ 32'h10); src_q.push_back(last ^ 32'h30);
        make_expect(3);
        do_fill(9'h002, -1);
        n_cmp++;
        if (wr_cnt != 3 || wr_data_q[0] !== last) begin
            n_fail++; $display("FAIL repeat_first_uncompared: got n=%0d %h want 3 %h", wr_cnt, wr_data_q[0], last);
        end
        n_cmp++; if (health_fail !== exp_hf) begin n_fail++; $display("FAIL repeat_health_sticky: got %b want %b", health_fail, exp_hf); end
    endtask

    initial begin
        clean_knobs();
        test_reset();
        test_counter();
        test_single();
        test_stall();
        test_gap_rereq();
        test_reset_mid();
        test_boundary_max();
        test_random();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rng_fill.md
RNG_FILL -- requirements
Module: rng_fill

Interface
REQ-001 clk_i  input  1  sole clock; all logic on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-high.
REQ-003 we_rng  input  1  fill request pulse from the AES sequencer.
REQ-004 addr_rng  input  9  last RAM word address to fill; sampled with we_rng.
REQ-005 ack_rng  output  1  one-cycle pulse: fill complete.
REQ-006 busy  output  1  high from request acceptance through the ack_rng cycle.
REQ-007 rnd_vld  input  1  entropy source word valid.
REQ-008 rnd_data  input  32  entropy source word.
REQ-009 rnd_rdy  output  1  entropy word consumed when rnd_vld && rnd_rdy.
REQ-010 ram_cyc_a, ram_stb_a  output  1 each  RAM port A pipelined bus cycle/strobe.
REQ-011 ram_we_a  output  4  byte write enables; 4'hF while ram_stb_a is high, else 0.
REQ-012 ram_addr_a  output  9  RAM word address.
REQ-013 ram_data_in_a  output  32  RAM write data.
REQ-014 ram_ack_a, ram_stall_a  input  1 each  RAM acknowledge / stall.
REQ-015 health_fail  output  1  sticky entropy health failure (see Configuration).

Function
REQ-016 States: IDLE, GET_RND, WRITE, WAIT_ACK, DONE.
REQ-017 IDLE: on we_rng=1, latch end_addr=addr_rng, set cur_addr=0, go to GET_RND.
REQ-018 we_rng outside IDLE shall be ignored; the latched end_addr does not change.
REQ-019 GET_RND: rnd_rdy=1; on rnd_vld, capture rnd_data into a 32-bit write register and go to WRITE; otherwise hold.
REQ-020 rnd_rdy shall be 0 in every other state.
REQ-021 WRITE: ram_cyc_a=1, ram_stb_a=1, ram_addr_a=cur_addr, ram_data_in_a=write register.
REQ-022 WRITE: stb, address and data stay stable while ram_stall_a=1.
REQ-023 WRITE: request accepted when ram_stall_a=0; go to WAIT_ACK.
REQ-024 WAIT_ACK: ram_cyc_a=1, ram_stb_a=0.
REQ-025 WAIT_ACK, ram_ack_a=1 and cur_addr!=end_addr: cur_addr+1, go to GET_RND.
REQ-026 WAIT_ACK, ram_ack_a=1 and cur_addr==end_addr: go to DONE.
REQ-027 ram_cyc_a shall drop to 0 in GET_RND between words.
REQ-028 ram_ack_a outside WAIT_ACK shall be ignored.
REQ-029 DONE: ack_rng=1 for exactly one cycle, then IDLE; a we_rng in the DONE cycle is ignored.
REQ-030 Boundaries: addr_rng=0x000 fills one word; addr_rng=0x1FF fills 512 words.
REQ-031 cur_addr is 9-bit and never wraps past end_addr.
REQ-032 Latency with rnd_vld=1, no stall and ack one cycle after acceptance: 3 cycles per word.
REQ-033 Latency: ack_rng rises 3*(end_addr+1)+1 cycles after the we_rng cycle.
REQ-034 busy=1 in every state except IDLE.

Reset
REQ-035 rst_i=1 forces IDLE immediately, regardless of clock.
REQ-036 Reset clears all outputs to 0, and clears cur_addr, end_addr, the write register and health state.
REQ-037 Reset mid-fill abandons the bus cycle (cyc/stb low at once); no ack_rng is issued for the aborted request.

Configuration
REQ-038 Macro RNG_FILL_HEALTH_EN defined: GET_RND compares each consumed word with the previous consumed word.
REQ-039 With RNG_FILL_HEALTH_EN, an equal word is discarded (not written, stays in GET_RND) and sets health_fail=1 until reset.
REQ-040 With RNG_FILL_HEALTH_EN, the first word after reset or after a request is never compared.
REQ-041 Macro undefined: no comparison, every consumed word is written, health_fail tied 0.

Verification
REQ-042 addr_rng=0x1F, rnd_vld=1, data=counter 1,2,3..., no stall, ack 1 cycle later -> words 0x00..0x1F hold 1..32; ack_rng one pulse at cycle 97.
REQ-043 addr_rng=0x000 -> exactly one write to 0x000; ack_rng at cycle 4; busy low the cycle after.
REQ-044 ram_stall_a high 5 cycles on word 3 -> addr/data/stb stable for those cycles, single write per address, total latency +5.
REQ-045 rnd_vld low 10 cycles mid-fill; second we_rng pulse while busy -> fill pauses, no extra fill, single ack_rng.
REQ-046 rst_i asserted during WAIT_ACK of word 7 -> cyc/stb/busy/ack_rng 0 asynchronously; a new request afterwards restarts at address 0.
REQ-047 RNG_FILL_HEALTH_EN, stream A,A,B -> A at 0x00, B at 0x01, health_fail=1 sticky; without macro A,A,B at 0x00..0x02, health_fail=0.
